// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared MIPS instruction/data memory port.
// Define MEM_ARB_LOCK_EN to build the bounded port-1 burst lock (LOCK1 state, burst_cnt, m1_lock).
module mem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic [DATA_W-1:0] m1_wd,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [15:0]       conflicts
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wd;
  } acc_t;

  state_t state;
  logic   last;
  logic   both, g0, g1, rd0, rd1;
  acc_t   a0, a1, sel;

`ifdef MEM_ARB_LOCK_EN
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  logic [3:0] burst_cnt;
`else
  logic unused_ok;
  assign unused_ok = ^{m1_lock, state};
`endif

  always_comb begin
    both = m0_req & m1_req;
    g0   = 1'b0;
    g1   = 1'b0;
    if (both) begin
      g1 = ~last;
`ifdef MEM_ARB_LOCK_EN
      // a held lock keeps port 1 until it has used MAX_BURST slots
      if (state == LOCK1) g1 = (burst_cnt < MAXB);
`endif
      g0 = ~g1;
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
    if (!reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign a0  = '{we: m0_we, adr: m0_adr, wd: m0_wd};
  assign a1  = '{we: m1_we, adr: m1_adr, wd: m1_wd};
  assign sel = g1 ? a1 : a0;

  assign m0_gnt  = g0;
  assign m1_gnt  = g1;
  assign mem_adr = sel.adr;
  assign mem_wd  = sel.wd;
  assign mem_we  = (g0 & m0_we) | (g1 & m1_we);
  assign rd0     = g0 & ~m0_we;
  assign rd1     = g1 & ~m1_we;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      rdata     <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      conflicts <= '0;
`ifdef MEM_ARB_LOCK_EN
      burst_cnt <= '0;
`endif
    end else begin
      m0_rvalid <= rd0;
      m1_rvalid <= rd1;
      if (rd0 | rd1) rdata <= mem_rd;
      if (both && conflicts != 16'hFFFF) conflicts <= conflicts + 16'd1;
      if (g0) begin
        state <= OWN0;
        last  <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
        burst_cnt <= '0;
`endif
      end else if (g1) begin
        last <= 1'b1;
`ifdef MEM_ARB_LOCK_EN
        if (m1_lock) begin
          state <= LOCK1;
          if (burst_cnt != MAXB) burst_cnt <= burst_cnt + 4'd1;
        end else begin
          state     <= OWN1;
          burst_cnt <= '0;
        end
`else
        state <= OWN1;
`endif
      end else begin
        state <= IDLE;
`ifdef MEM_ARB_LOCK_EN
        burst_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, a slot-level model checked every negedge,
// and literal expectations for the key scenarios.
module tb_mem_arbiter;
  localparam int DW = 32, AW = 32, MAXB = 4;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0, reset;
  logic m0_req, m1_req, m0_we, m1_we, m1_lock;
  logic [AW-1:0] m0_adr, m1_adr, mem_adr;
  logic [DW-1:0] m0_wd, m1_wd, mem_wd, mem_rd, rdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [15:0] conflicts;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m1_lock(m1_lock), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .rdata(rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .mem_adr(mem_adr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owned the memory last, how many consecutive locked slots port 1 has had.
  bit model_ok = 1'b0;
  int m_last, m_run, m_conf, m_locked;
  logic [DW-1:0] m_rdata;
  bit m_rv0, m_rv1;

  function automatic int pick();
    if (!reset) return -1;
    if (m0_req && m1_req) begin
      if (LOCK_EN && m_locked != 0) return (m_run < MAXB) ? 1 : 0;
      return (m_last == 1) ? 0 : 1;
    end
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!reset) begin
      model_ok = 1'b1;
      m_last = 1; m_run = 0; m_conf = 0; m_locked = 0;
      m_rdata = '0; m_rv0 = 0; m_rv1 = 0;
    end else if (model_ok) begin
      w = pick();
      m_rv0 = (w == 0) && !m0_we;
      m_rv1 = (w == 1) && !m1_we;
      if (m_rv0 || m_rv1) m_rdata = mem_rd;
      if (m0_req && m1_req && m_conf < 65535) m_conf++;
      if (w == 0) begin
        m_last = 0; m_run = 0; m_locked = 0;
      end else if (w == 1) begin
        m_last = 1;
        if (LOCK_EN && m1_lock) begin
          m_locked = 1;
          if (m_run < MAXB) m_run++;
        end else begin
          m_locked = 0; m_run = 0;
        end
      end else begin
        m_locked = 0; m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (model_ok) begin
      w = pick();
      chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
      chk("mem_we", 32'(mem_we), 32'(((w == 0) && m0_we) || ((w == 1) && m1_we)));
      chk("mem_adr", mem_adr, (w == 1) ? m1_adr : m0_adr);
      chk("mem_wd", mem_wd, (w == 1) ? m1_wd : m0_wd);
      chk("rdata", rdata, m_rdata);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(m_rv0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(m_rv1));
      chk("conflicts", 32'(conflicts), 32'(m_conf));
    end
  end

  // Inputs change 1 unit after a rising edge; directed checks run 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:3] alt;
    logic [0:9] lockseq;
    reset = 1'b0; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m1_lock = 0;
    m0_adr = '0; m1_adr = '0; m0_wd = '0; m1_wd = '0; mem_rd = '0;
    alt = 4'b0101;
    lockseq = 10'b1111011110;

    // reset: grants and write strobe forced low even with requests present
    step();
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    #3;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    step();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_conflicts", 32'(conflicts), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);

    // uncontended port-0 read
    reset = 1; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_adr = 32'h10; mem_rd = 32'hDEADBEEF;
    #3;
    chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rd_mem_adr", mem_adr, 32'h10);
    step();
    m0_req = 0; mem_rd = 32'h0;
    #3;
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);

    // port-1 write with port 0 idle
    step();
    m1_req = 1; m1_we = 1; m1_adr = 32'h40; m1_wd = 32'h55;
    #3;
    chk("wr_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_adr", mem_adr, 32'h40);
    chk("wr_mem_wd", mem_wd, 32'h55);
    step();
    m1_req = 0; m1_we = 0;
    #3;
    chk("wr_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("wr_rdata_hold", rdata, 32'hDEADBEEF);

    // both request from reset: 0,1,0,1 and one conflict per cycle
    step();
    reset = 0; m0_req = 1; m1_req = 1; m0_adr = 32'h100; m1_adr = 32'h200; mem_rd = 32'h1234;
    step();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("alt_m0_gnt", 32'(m0_gnt), 32'(!alt[i]));
      chk("alt_m1_gnt", 32'(m1_gnt), 32'(alt[i]));
      chk("alt_conflicts", 32'(conflicts), 32'(i));
      step();
    end

`ifdef MEM_ARB_LOCK_EN
    // port 0 alone first so port 1 is next in line, then locked contention
    m1_req = 0;
    step();
    m1_req = 1; m1_lock = 1;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("lock_m1_gnt", 32'(m1_gnt), 32'(lockseq[i]));
      step();
    end
    #3;
    chk("lock_hold", 32'(m1_gnt), 32'd1);
    step();
`else
    if (lockseq[0]) m1_lock = 1;
`endif

    // reset while port 1 is reading under contention
    reset = 0;
    #3;
    chk("midrst_m1_gnt", 32'(m1_gnt), 32'd0);
    step();
    reset = 1;
    #3;
    chk("midrst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("midrst_conflicts", 32'(conflicts), 32'd0);
    chk("midrst_first_m0", 32'(m0_gnt), 32'd1);

    // long contention saturates the conflict counter
    for (int i = 0; i < 70000; i++) step();
    #3;
    chk("conf_sat", 32'(conflicts), 32'hFFFF);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
